// File: rtl/alu_share_arbiter_pkg.sv
// Shared processor package: ALU opcode encoding and the arbiter response record.
package alu_share_arbiter_pkg;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpNot = 3'd5;
  localparam logic [2:0] OpShl = 3'd6;
  localparam logic [2:0] OpShr = 3'd7;

  typedef struct packed {
    logic       id;
    logic [7:0] result;
    logic       zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// ALU8Bit: purely combinational 8-bit ALU; results wrap, no carry out.
module ALU8Bit
  import alu_share_arbiter_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       zero
);

  always_comb begin
    result = 8'h00;
    case (opcode)
      OpAdd:   result = a + b;
      OpSub:   result = a - b;
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpNot:   result = ~a;
      OpShl:   result = a << b[2:0];
      OpShr:   result = a >> b[2:0];
      default: result = 8'h00;
    endcase
    zero = (result == 8'h00);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU8Bit, with a single registered
// response slot and saturating per-requester accept counters.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_opcode,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_opcode,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_result,
  output logic        rsp_zero,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
);

  localparam logic PrioInit = (PRIO_INIT != 0);

  // prio_q holds the index that wins the next contended cycle.
  logic        prio_q, prio_d;
  alu_rsp_t    rsp_q, rsp_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic       free, grant0, grant1, accept0, accept1, accept, sel;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_zero;

  always_comb begin
    free    = ~rsp_valid_q | rsp_ready;
    grant0  = req0_valid & (~req1_valid | ~prio_q);
    grant1  = req1_valid & (~req0_valid | prio_q);
    accept0 = grant0 & free & ~reset;
    accept1 = grant1 & free & ~reset;
    accept  = accept0 | accept1;
    sel     = grant1;
    alu_op  = sel ? req1_opcode : req0_opcode;
    alu_a   = sel ? req1_a : req0_a;
    alu_b   = sel ? req1_b : req0_b;
  end

  ALU8Bit u_alu (
    .opcode(alu_op),
    .a     (alu_a),
    .b     (alu_b),
    .result(alu_result),
    .zero  (alu_zero)
  );

  always_comb begin
    prio_d      = prio_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (accept) begin
      prio_d       = ~sel;
      rsp_d.id     = sel;
      rsp_d.result = alu_result;
      rsp_d.zero   = alu_zero;
      rsp_valid_d  = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
    if (accept0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (accept1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q      <= PrioInit;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cnt0_q      <= 16'h0000;
      cnt1_q      <= 16'h0000;
    end else begin
      prio_q      <= prio_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign req0_ready = accept0;
  assign req1_ready = accept1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_zero   = rsp_q.zero;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, scoreboard of accepted ops, and
// hand-written contention, backpressure, async-reset and saturation sequences.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_opcode, req1_opcode;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [7:0]  rsp_result;
  logic [15:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
  } vec_t;

  vec_t     vecs[11];
  alu_rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.PRIO_INIT(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_opcode(req0_opcode),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_opcode(req1_opcode),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpNot:   return ~a;
      OpShl:   return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  function automatic alu_rsp_t expect_rsp(input logic id, input logic [2:0] op,
                                          input logic [7:0] a, input logic [7:0] b);
    alu_rsp_t r;
    r.id     = id;
    r.result = alu_model(op, a, b);
    r.zero   = (r.result == 8'h00);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    if (n == 0) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end
  endtask

  // Pushes on every accepted handshake, pops on every drained response.
  task automatic monitor();
    alu_rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_rsp", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk("sb_rsp", 32'({rsp_id, rsp_result, rsp_zero}), 32'(e));
          end
        end
        if (req0_valid && req0_ready)
          exp_q.push_back(expect_rsp(1'b0, req0_opcode, req0_a, req0_b));
        if (req1_valid && req1_ready)
          exp_q.push_back(expect_rsp(1'b1, req1_opcode, req1_a, req1_b));
      end
    end
  endtask

  initial begin
    bit hit;
    vecs[0]  = '{OpAdd, 8'h05, 8'h03, 8'h08, 1'b0};
    vecs[1]  = '{OpAdd, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2]  = '{OpSub, 8'h03, 8'h05, 8'hFE, 1'b0};
    vecs[3]  = '{OpSub, 8'h42, 8'h42, 8'h00, 1'b1};
    vecs[4]  = '{OpAnd, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[5]  = '{OpOr,  8'h0F, 8'h30, 8'h3F, 1'b0};
    vecs[6]  = '{OpXor, 8'hAA, 8'hAA, 8'h00, 1'b1};
    vecs[7]  = '{OpNot, 8'h0F, 8'h55, 8'hF0, 1'b0};
    vecs[8]  = '{OpShl, 8'h81, 8'h01, 8'h02, 1'b0};
    vecs[9]  = '{OpShr, 8'h80, 8'h07, 8'h01, 1'b0};
    vecs[10] = '{OpAdd, 8'h80, 8'h80, 8'h00, 1'b1};

    reset = 1'b1;
    rsp_ready = 1'b0;
    drive(0, 1'b0, OpAdd, 8'h00, 8'h00);
    drive(1, 1'b0, OpAdd, 8'h00, 8'h00);
    fork
      monitor();
    join_none

    // Reset state, and ready held low while reset is high.
    #2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'(0));
    chk("rst_ready1", 32'(req1_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp", 32'({rsp_id, rsp_result, rsp_zero}), 32'(0));
    chk("rst_cnt0", 32'(grant_cnt0), 32'(0));
    chk("rst_cnt1", 32'(grant_cnt1), 32'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Solo requester: ADD 5+3.
    step();
    rsp_ready = 1'b1;
    drive(0, 1'b1, OpAdd, 8'h05, 8'h03);
    @(negedge clk);
    chk("solo_ready0", 32'(req0_ready), 32'(1));
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("solo_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("solo_rsp_id", 32'(rsp_id), 32'(0));
    chk("solo_result", 32'(rsp_result), 32'h08);
    chk("solo_zero", 32'(rsp_zero), 32'(0));
    chk("solo_cnt0", 32'(grant_cnt0), 32'(1));

    // Vector table, alternating requesters.
    for (int i = 0; i < 11; i++) begin
      step();
      drive(i % 2, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("vec_valid", 32'(rsp_valid), 32'(1));
      chk("vec_result", 32'(rsp_result), 32'(vecs[i].res));
      chk("vec_zero", 32'(rsp_zero), 32'(vecs[i].zero));
      chk("vec_id", 32'(rsp_id), 32'(i % 2));
    end

    // Contention from reset: grants alternate 0,1,0,1 at full throughput.
    step();
    reset = 1'b1;
    step();
    exp_q.delete();
    reset = 1'b0;
    drive(0, 1'b1, OpAdd, 8'h01, 8'h01);
    drive(1, 1'b1, OpSub, 8'h09, 8'h04);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      chk("cont_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      if (i > 0) begin
        chk("cont_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("cont_rsp_id", 32'(rsp_id), 32'((i - 1) % 2));
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("cont_last_id", 32'(rsp_id), 32'(1));
    chk("cont_cnt0", 32'(grant_cnt0), 32'(2));
    chk("cont_cnt1", 32'(grant_cnt1), 32'(2));

    // Backpressure: hold for 3 cycles, then drain and accept together.
    step();
    drive(0, 1'b1, OpAdd, 8'h10, 8'h20);
    step();
    rsp_ready = 1'b0;
    drive(0, 1'b1, OpOr, 8'h01, 8'h02);
    drive(1, 1'b1, OpXor, 8'hF0, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready0", 32'(req0_ready), 32'(0));
      chk("bp_ready1", 32'(req1_ready), 32'(0));
      chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_result, rsp_zero}), 32'({1'b1, 1'b0, 8'h30, 1'b0}));
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ready0", 32'(req0_ready), 32'(0));
    chk("bp_rel_ready1", 32'(req1_ready), 32'(1));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_next", 32'({rsp_valid, rsp_id, rsp_result, rsp_zero}), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
    step();
    @(negedge clk);
    chk("drain_only_valid", 32'(rsp_valid), 32'(0));

    // Async reset with a pending, undrained response.
    step();
    rsp_ready = 1'b0;
    drive(1, 1'b1, OpSub, 8'h07, 8'h02);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("ar_pending", 32'({rsp_valid, rsp_id, rsp_result}), 32'({1'b1, 1'b1, 8'h05}));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("ar_rsp", 32'({rsp_id, rsp_result, rsp_zero}), 32'(0));
    chk("ar_cnt", 32'({grant_cnt0, grant_cnt1}), 32'(0));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ar_no_replay", 32'(rsp_valid), 32'(0));
    end

    // Counter saturation: run req1 up to 16'hFFFE, then 3 more ops.
    step();
    drive(1, 1'b1, OpAdd, 8'h01, 8'h01);
    hit = 1'b0;
    for (int n = 0; n < 70000; n++) begin
      step();
      if (grant_cnt1 == 16'hFFFE) begin
        hit = 1'b1;
        break;
      end
    end
    req1_valid = 1'b0;
    chk("sat_reached", 32'(hit), 32'(1));
    chk("sat_pre", 32'(grant_cnt1), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1, 1'b1, OpXor, 8'(i), 8'h03);
      step();
      req1_valid = 1'b0;
    end
    @(negedge clk);
    chk("sat_cnt1", 32'(grant_cnt1), 32'hFFFF);
    chk("sat_cnt0", 32'(grant_cnt0), 32'(0));

    step();
    step();
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, 0, requester index (0/1) that wins the first contended cycle after reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Ports: reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 Ports: reqN_ready  output  1  operation from requester N is accepted this cycle.
REQ-006 Ports: reqN_opcode  input  3  ALU opcode, with the same encoding as ALU8Bit.
REQ-007 Ports: reqN_a, reqN_b  input  8  ALU operands.
REQ-008 Port: rsp_valid  output  1  response register holds a result.
REQ-009 Port: rsp_ready  input  1  consumer takes the response this cycle.
REQ-010 Port: rsp_id  output  1  requester index owning the response.
REQ-011 Port: rsp_result  output  8  registered ALU result.
REQ-012 Port: rsp_zero  output  1  registered ALU zero flag.
REQ-013 Ports: grant_cnt0, grant_cnt1  output  16  accepted-operation counters per requester.

Function
REQ-014 Single shared combinational ALU; at most one operation SHALL be accepted per cycle.
REQ-015 Slot-free condition: free = ~rsp_valid | rsp_ready.
REQ-016 Grant with one valid requester: that requester SHALL be granted.
REQ-017 Grant with both requesters valid: the requester not granted last SHALL be granted (round-robin pointer).
REQ-018 Pointer: the round-robin pointer SHALL update only on an accepted handshake, never on grant alone.
REQ-019 Ready: reqN_ready SHALL equal grantN & free, be combinational from valids/pointer/rsp_valid/rsp_ready, and SHALL NOT depend on reqN_ready of the other port.
REQ-020 Latency: an operation accepted at edge k SHALL present rsp_valid=1 with its result, zero flag and id after edge k, i.e. 1-cycle latency.
REQ-021 Drain and accept: simultaneous drain (rsp_valid & rsp_ready) and accept SHALL load the new response with no bubble, giving full throughput.
REQ-022 Drain only: drain without accept SHALL clear rsp_valid at the next edge.
REQ-023 Hold: while rsp_valid & ~rsp_ready, rsp_result/rsp_zero/rsp_id SHALL hold stable and both reqN_ready SHALL be 0.
REQ-024 Width: the result SHALL be 8-bit with wrap-around exactly as ALU8Bit computes; no carry output.
REQ-025 Counters: grant_cntN SHALL increment on each accepted handshake of requester N and saturate at 16'hFFFF.
REQ-026 Requester behaviour: requesters may drop valid without handshake; the arbiter SHALL NOT record such a cycle.

Reset
REQ-027 Asserting reset SHALL immediately force rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, grant_cnt0/1=0 and set the pointer so PRIO_INIT wins the next contention.
REQ-028 Reset mid-operation: a pending undrained response SHALL be discarded, not replayed.
REQ-029 Ready during reset: while reset is high, both reqN_ready SHALL be 0.

Structure
REQ-030 Shared package: ALU opcode constants and the response record typedef (id, result, zero) SHALL live in the shared processor package.
REQ-031 Sub-modules: exactly one ALU8Bit instance for the datapath; arbitration and the response register SHALL be in this module, with no further sub-module.

Verification
REQ-032 Solo requester: reset, req0 opcode ADD a=8'h05 b=8'h03 valid one cycle, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=8'h08, rsp_zero=0, grant_cnt0=1.
REQ-033 Contention: both valid continuously with PRIO_INIT=0, rsp_ready=1 -> grants alternate 0,1,0,1 with one response per cycle; after 4 cycles grant_cnt0=2 and grant_cnt1=2.
REQ-034 Backpressure: rsp_ready=0 for 3 cycles after an accept -> response held stable, both ready=0; rsp_ready=1 -> drain plus the next accept in the same cycle.
REQ-035 Zero and wrap: ADD a=8'hFF b=8'h01 -> rsp_result=8'h00, rsp_zero=1.
REQ-036 Async reset with pending response: reset asserted between edges while rsp_valid=1 -> outputs zero immediately; after release rsp_valid stays 0 until a new accept.
REQ-037 Counter saturation: force/preload grant_cnt1=16'hFFFE, issue 3 req1 operations -> counter reads 16'hFFFF.
